// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM encoding
// and the oversample divisor helpers.
// Latency: n/a (package). Backpressure: n/a (package).
package uart_pkg;

   // Parity mode encodings for the PARITY parameter
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } rx_state_e;

   // Clocks per 1/16-bit oversample tick, truncated
   function automatic int dvsr(input int clk_hz, input int baud);
      return clk_hz / (16 * baud);
   endfunction

   // Counter width needed to count 0..d-1 (never narrower than 1 bit)
   function automatic int dvsr_w(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Registered synchronous FIFO, B-bit words, 2**W entries.
// Latency: write visible at the head one cycle after wr; r_data is the current head.
// Backpressure: wr while full is dropped unless rd pops in the same cycle; rd on empty is ignored.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   wr, w_data        push request and data
//   rd                pop request
//   r_data            head entry (valid while empty=0)
//   empty, full, fill status and occupancy 0..2**W
module uart_sync_fifo #(
   parameter int B = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   input  logic         rd,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic [W:0]   fill
);

   localparam int         DEPTH   = 1 << W;
   localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);

   logic [B-1:0] mem_q [DEPTH];
   logic [B-1:0] mem_d [DEPTH];
   logic [W-1:0] wr_ptr_q, wr_ptr_d;
   logic [W-1:0] rd_ptr_q, rd_ptr_d;
   logic [W:0]   cnt_q, cnt_d;
   logic         do_rd, do_wr;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == DEPTH_C);
   assign fill   = cnt_q;
   assign r_data = mem_q[rd_ptr_q];

   // A pop frees the slot the push needs, so a full FIFO still accepts a
   // write when both happen in the same cycle.
   assign do_rd = rd && !empty;
   assign do_wr = wr && (!full || do_rd);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = w_data;
         wr_ptr_d        = wr_ptr_q + W'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + W'(1);
      end
      case ({do_wr, do_rd})
         2'b10:   cnt_d = cnt_q + (W+1)'(1);
         2'b01:   cnt_d = cnt_q - (W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver with 16x oversampling, optional parity, RX FIFO and last-word latch.
// Latency: byte reaches the FIFO one cycle after mid-stop "done"; auto-pop adds one more cycle to word.
// Backpressure: none on the line; a good byte arriving at a full FIFO with no pop is dropped and flagged.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   rx                  serial line (idle high, asynchronous)
//   rd                  external FIFO pop (used only when AUTO_POP=0)
//   err_clr             clears the sticky error flags
//   r_data, rx_empty, rx_full, fill   FIFO head and status
//   word, word_valid    last popped byte and its 1-cycle update strobe
//   frame_err, parity_err, overrun    sticky error flags
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_HZ   = 65_000_000,
   parameter int BAUD     = 9600,
   parameter int DBIT     = 8,
   parameter int PARITY   = 0,
   parameter int SB_TICK  = 16,
   parameter int FIFO_W   = 2,
   parameter int AUTO_POP = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   input  logic              rd,
   input  logic              err_clr,
   output logic [DBIT-1:0]   r_data,
   output logic              rx_empty,
   output logic              rx_full,
   output logic [FIFO_W:0]   fill,
   output logic [DBIT-1:0]   word,
   output logic              word_valid,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun
);

   localparam int DVSR = dvsr(CLK_HZ, BAUD);
   localparam int CW   = dvsr_w(DVSR);
   // Tick counter must reach SB_TICK-1, which needs a 5th bit for 1.5/2 stop bits
   localparam int SW   = (SB_TICK > 16) ? 5 : 4;
   localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   // ---------------- state ----------------
   logic [1:0]      sync_q, sync_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   rx_state_e       state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            par_bad_q, par_bad_d;
   logic            stop_bad_q, stop_bad_d;
   logic            armed_q, armed_d;
   logic            popped_q, popped_d;
   logic [DBIT-1:0] word_q, word_d;
   logic            word_valid_q, word_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            parity_err_q, parity_err_d;
   logic            overrun_q, overrun_d;

   // ---------------- combinational ----------------
   logic            rx_s;
   logic            tick;
   logic            done;
   logic            frame_bad;
   logic            stop_now_bad;
   logic            exp_par;
   logic            good;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   logic [DBIT-1:0] fifo_head;

   assign rx_s = sync_q[1];
   assign tick = (cnt_q == CW'(DVSR - 1));

   // Synchroniser and free-running baud tick generator
   always_comb begin
      sync_d = {sync_q[0], rx};
      cnt_d  = tick ? '0 : cnt_q + CW'(1);
   end

   // Receive FSM
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      par_bad_d    = par_bad_q;
      stop_bad_d   = stop_bad_q;
      armed_d      = armed_q;
      done         = 1'b0;
      frame_bad    = 1'b0;
      stop_now_bad = 1'b0;
      exp_par      = (PARITY == PAR_ODD) ? ~(^b_q) : (^b_q);

      case (state_q)
         ST_IDLE: begin
            // After a break the line may still be low; wait for a high tick
            // before accepting a falling edge as a new start bit.
            if (tick && rx_s) begin
               armed_d = 1'b1;
            end
            if (!rx_s && armed_q) begin
               state_d = ST_START;
               s_d     = '0;
            end
         end

         ST_START: begin
            if (tick) begin
               if (s_q == SW'(7)) begin
                  if (!rx_s) begin
                     state_d    = ST_DATA;
                     s_d        = '0;
                     n_d        = '0;
                     par_bad_d  = 1'b0;
                     stop_bad_d = 1'b0;
                  end else begin
                     // Too short to be a start bit: silently ignore
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (s_q == SW'(15)) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  if (n_q == NW'(DBIT - 1)) begin
                     state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         ST_PAR: begin
            if (tick) begin
               if (s_q == SW'(15)) begin
                  s_d       = '0;
                  par_bad_d = (rx_s != exp_par);
                  state_d   = ST_STOP;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               // With one stop bit the sample and frame end share a tick,
               // so the live sample is used directly in that case.
               stop_now_bad = (s_q == SW'(15)) ? !rx_s : stop_bad_q;
               if (s_q == SW'(15)) begin
                  stop_bad_d = !rx_s;
               end
               if (s_q == SW'(SB_TICK - 1)) begin
                  done      = 1'b1;
                  frame_bad = stop_now_bad;
                  armed_d   = !stop_now_bad;
                  state_d   = ST_IDLE;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign good = done && !frame_bad && !par_bad_q;

   // Pop selection, word latch and sticky error flags
   always_comb begin
      pop = 1'b0;
      if (AUTO_POP != 0) begin
         // Skip a cycle after each pop so every word_valid is a separate pulse
         pop = !fifo_empty && !popped_q;
      end else begin
         pop = rd && !fifo_empty;
      end
      popped_d     = pop;
      word_d       = pop ? fifo_head : word_q;
      word_valid_d = pop;

      frame_err_d  = (frame_err_q  && !err_clr) || (done && frame_bad);
      parity_err_d = (parity_err_q && !err_clr) || (done && par_bad_q);
      overrun_d    = (overrun_q    && !err_clr) || (good && fifo_full && !pop);
   end

   uart_sync_fifo #(
      .B (DBIT),
      .W (FIFO_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (good),
      .w_data  (b_q),
      .rd      (pop),
      .r_data  (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .fill    (fill)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         state_q      <= ST_IDLE;
         s_q          <= '0;
         n_q          <= '0;
         b_q          <= '0;
         par_bad_q    <= 1'b0;
         stop_bad_q   <= 1'b0;
         armed_q      <= 1'b1;
         popped_q     <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         b_q          <= b_d;
         par_bad_q    <= par_bad_d;
         stop_bad_q   <= stop_bad_d;
         armed_q      <= armed_d;
         popped_q     <= popped_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign r_data     = fifo_head;
   assign rx_empty   = fifo_empty;
   assign rx_full    = fifo_full;
   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: three instances (auto-pop, even parity,
// external-pop) at a fast line rate, scoreboard queues checked on word_valid.
// Latency: n/a. Backpressure: n/a.
module tb_uart_rx_ctrl;

   localparam int CLK_HZ = 1_600_000;
   localparam int BAUD   = 25_000;
   localparam int TICK   = CLK_HZ / (16 * BAUD);   // 4 clocks per tick
   localparam int BIT    = 16 * TICK;              // 64 clocks per bit

   logic clk = 1'b0;
   logic reset_n;
   logic err_clr;
   logic rd_m;
   logic line;
   int   tgt;

   always #5 clk = ~clk;

   logic rx_a, rx_p, rx_m;
   assign rx_a = (tgt == 0) ? line : 1'b1;
   assign rx_p = (tgt == 1) ? line : 1'b1;
   assign rx_m = (tgt == 2) ? line : 1'b1;

   logic [7:0] r_data_a, word_a, r_data_p, word_p, r_data_m, word_m;
   logic [2:0] fill_a, fill_p, fill_m;
   logic rx_empty_a, rx_full_a, word_valid_a, frame_err_a, parity_err_a, overrun_a;
   logic rx_empty_p, rx_full_p, word_valid_p, frame_err_p, parity_err_p, overrun_p;
   logic rx_empty_m, rx_full_m, word_valid_m, frame_err_m, parity_err_m, overrun_m;

   uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DBIT(8), .PARITY(0), .SB_TICK(16),
                  .FIFO_W(2), .AUTO_POP(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(rx_a), .rd(1'b0), .err_clr(err_clr),
      .r_data(r_data_a), .rx_empty(rx_empty_a), .rx_full(rx_full_a), .fill(fill_a),
      .word(word_a), .word_valid(word_valid_a), .frame_err(frame_err_a),
      .parity_err(parity_err_a), .overrun(overrun_a));

   uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DBIT(8), .PARITY(1), .SB_TICK(16),
                  .FIFO_W(2), .AUTO_POP(1)) dut_p (
      .clk(clk), .reset_n(reset_n), .rx(rx_p), .rd(1'b0), .err_clr(err_clr),
      .r_data(r_data_p), .rx_empty(rx_empty_p), .rx_full(rx_full_p), .fill(fill_p),
      .word(word_p), .word_valid(word_valid_p), .frame_err(frame_err_p),
      .parity_err(parity_err_p), .overrun(overrun_p));

   uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DBIT(8), .PARITY(0), .SB_TICK(16),
                  .FIFO_W(2), .AUTO_POP(0)) dut_m (
      .clk(clk), .reset_n(reset_n), .rx(rx_m), .rd(rd_m), .err_clr(err_clr),
      .r_data(r_data_m), .rx_empty(rx_empty_m), .rx_full(rx_full_m), .fill(fill_m),
      .word(word_m), .word_valid(word_valid_m), .frame_err(frame_err_m),
      .parity_err(parity_err_m), .overrun(overrun_m));

   int vecs    = 0;
   int miscmp  = 0;
   int wv_a    = 0;
   int wv_p    = 0;
   int wv_m    = 0;
   logic [7:0]  q_a[$];
   logic [7:0]  q_p[$];
   logic [7:0]  q_m[$];
   logic [31:0] exp_a, exp_p, exp_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboards: each word_valid pulse must match the oldest expected byte
   always @(negedge clk) begin
      if (reset_n && word_valid_a) begin
         wv_a++;
         exp_a = 32'hDEAD;
         if (q_a.size() != 0) exp_a = {24'h0, q_a.pop_front()};
         chk("word_a", {24'h0, word_a}, exp_a);
      end
      if (reset_n && word_valid_p) begin
         wv_p++;
         exp_p = 32'hDEAD;
         if (q_p.size() != 0) exp_p = {24'h0, q_p.pop_front()};
         chk("word_p", {24'h0, word_p}, exp_p);
      end
      if (reset_n && word_valid_m) begin
         wv_m++;
         exp_m = 32'hDEAD;
         if (q_m.size() != 0) exp_m = {24'h0, q_m.pop_front()};
         chk("word_m", {24'h0, word_m}, exp_m);
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int t, input logic [7:0] d, input bit has_par,
                       input logic pb, input logic stop_v);
      tgt  = t;
      line = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 8; i++) begin
         line = d[i];
         wait_clk(BIT);
      end
      if (has_par) begin
         line = pb;
         wait_clk(BIT);
      end
      line = stop_v;
      wait_clk(BIT);
      line = 1'b1;
      wait_clk(2 * BIT);
   endtask

   int wv0;

   initial begin
      reset_n = 1'b0;
      err_clr = 1'b0;
      rd_m    = 1'b0;
      line    = 1'b1;
      tgt     = 0;
      #23;
      chk("rst_rx_empty", {31'h0, rx_empty_a}, 32'h1);
      chk("rst_word", {24'h0, word_a}, 32'h0);
      chk("rst_word_valid", {31'h0, word_valid_a}, 32'h0);
      chk("rst_fill", {29'h0, fill_a}, 32'h0);
      chk("rst_errs", {29'h0, frame_err_a, parity_err_a, overrun_a}, 32'h0);
      chk("rst_r_data", {24'h0, r_data_a}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_clk(2 * BIT);

      // Clean byte
      wv0 = wv_a;
      q_a.push_back(8'h41);
      send(0, 8'h41, 1'b0, 1'b0, 1'b1);
      chk("41_drained", q_a.size(), 32'h0);
      chk("41_pulses", wv_a - wv0, 32'h1);
      chk("41_word", {24'h0, word_a}, 32'h41);
      chk("41_empty", {31'h0, rx_empty_a}, 32'h1);
      chk("41_errs", {29'h0, frame_err_a, parity_err_a, overrun_a}, 32'h0);

      // Stop bit forced low: frame error, byte dropped
      wv0 = wv_a;
      send(0, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("55_frame_err", {31'h0, frame_err_a}, 32'h1);
      chk("55_no_word", wv_a - wv0, 32'h0);
      chk("55_empty", {31'h0, rx_empty_a}, 32'h1);

      q_a.push_back(8'hAA);
      send(0, 8'hAA, 1'b0, 1'b0, 1'b1);
      chk("AA_word", {24'h0, word_a}, 32'hAA);
      chk("AA_drained", q_a.size(), 32'h0);
      chk("AA_sticky", {31'h0, frame_err_a}, 32'h1);
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      wait_clk(1);
      chk("clr_frame_err", {31'h0, frame_err_a}, 32'h0);

      // Glitch shorter than half a bit
      wv0  = wv_a;
      tgt  = 0;
      line = 1'b0;
      wait_clk(3 * TICK);
      line = 1'b1;
      wait_clk(2 * BIT);
      chk("glitch_no_word", wv_a - wv0, 32'h0);
      chk("glitch_no_err", {31'h0, frame_err_a}, 32'h0);
      q_a.push_back(8'h33);
      send(0, 8'h33, 1'b0, 1'b0, 1'b1);
      chk("33_word", {24'h0, word_a}, 32'h33);

      // Break: line low well past a frame, then high; must resync cleanly
      wv0  = wv_a;
      line = 1'b0;
      wait_clk(12 * BIT);
      line = 1'b1;
      wait_clk(12 * BIT);
      chk("break_frame_err", {31'h0, frame_err_a}, 32'h1);
      chk("break_no_word", wv_a - wv0, 32'h0);
      q_a.push_back(8'h5A);
      send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      chk("5A_word", {24'h0, word_a}, 32'h5A);
      chk("5A_drained", q_a.size(), 32'h0);

      // Even parity: 0x03 has two ones so a parity bit of 1 is wrong
      send(1, 8'h03, 1'b1, 1'b1, 1'b1);
      chk("par_err", {31'h0, parity_err_p}, 32'h1);
      chk("par_no_word", wv_p, 32'h0);
      chk("par_empty", {31'h0, rx_empty_p}, 32'h1);
      chk("par_no_frame_err", {31'h0, frame_err_p}, 32'h0);
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      wait_clk(1);
      chk("par_clr", {31'h0, parity_err_p}, 32'h0);
      q_p.push_back(8'h07);
      send(1, 8'h07, 1'b1, 1'b1, 1'b1);
      chk("par_07_word", {24'h0, word_p}, 32'h07);
      chk("par_07_ok", {31'h0, parity_err_p}, 32'h0);

      // External pop: five bytes into a four-deep FIFO
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) q_m.push_back(8'(k));
         send(2, 8'(k), 1'b0, 1'b0, 1'b1);
      end
      chk("m_fill", {29'h0, fill_m}, 32'h4);
      chk("m_full", {31'h0, rx_full_m}, 32'h1);
      chk("m_overrun", {31'h0, overrun_m}, 32'h1);
      chk("m_no_word", wv_m, 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk("m_head", {24'h0, r_data_m}, 32'(k + 1));
         rd_m = 1'b1;
         wait_clk(1);
         rd_m = 1'b0;
         wait_clk(2);
         chk("m_fill_pop", {29'h0, fill_m}, 32'(3 - k));
      end
      chk("m_empty", {31'h0, rx_empty_m}, 32'h1);
      chk("m_pops", wv_m, 32'h4);
      rd_m = 1'b1;
      wait_clk(1);
      rd_m = 1'b0;
      wait_clk(2);
      chk("m_pop_empty", wv_m, 32'h4);
      chk("m_fill_empty", {29'h0, fill_m}, 32'h0);

      // Reset in the middle of the data bits of 0x7E
      tgt  = 0;
      line = 1'b0;
      wait_clk(BIT);
      line = 1'b0; wait_clk(BIT);
      line = 1'b1; wait_clk(BIT);
      line = 1'b1; wait_clk(BIT);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_word", {24'h0, word_a}, 32'h0);
      chk("mid_rst_empty", {31'h0, rx_empty_a}, 32'h1);
      chk("mid_rst_fill", {29'h0, fill_a}, 32'h0);
      chk("mid_rst_overrun_m", {31'h0, overrun_m}, 32'h0);
      chk("mid_rst_word_m", {24'h0, word_m}, 32'h0);
      line = 1'b1;
      wait_clk(4);
      reset_n = 1'b1;
      wait_clk(2 * BIT);
      wv0 = wv_a;
      q_a.push_back(8'h12);
      send(0, 8'h12, 1'b0, 1'b0, 1'b1);
      chk("12_word", {24'h0, word_a}, 32'h12);
      chk("12_pulses", wv_a - wv0, 32'h1);
      chk("12_drained", q_a.size(), 32'h0);
      chk("12_no_err", {31'h0, frame_err_a}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised successor to the keyboard UART front end: a UART receiver with configurable data width, parity, stop length and RX FIFO depth. It adds frame, parity and overrun error detection and an optional auto-pop "last word" latch. It sits between the board RX pin and the game control logic, and it delivers bytes either through a rd/empty FIFO handshake or as a latched word with a 1-cycle valid strobe.

Parameters:
CLK_HZ, 65_000_000, system clock frequency in Hz
BAUD, 9600, line rate; DVSR = CLK_HZ/(16*BAUD), truncated (423 at defaults)
DBIT, 8, data bits per frame (5..9)
PARITY, 0, parity mode: 0 none, 1 even, 2 odd
SB_TICK, 16, oversample ticks of stop: 16/24/32 for 1/1.5/2 stop bits
FIFO_W, 2, FIFO address bits; depth 2**FIFO_W
AUTO_POP, 1, 1: block drains FIFO into word itself and ignores rd; 0: external rd

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
rx  in  1  serial line, idle high, asynchronous to clk
rd  in  1  pop FIFO head, only when AUTO_POP=0; ignored when rx_empty=1
err_clr  in  1  clears all sticky error flags
r_data  out  DBIT  FIFO head, valid while rx_empty=0
rx_empty  out  1  FIFO empty
rx_full  out  1  FIFO full
fill  out  FIFO_W+1  FIFO occupancy
word  out  DBIT  last byte popped; holds its value until the next pop
word_valid  out  1  1-cycle pulse on each word update
frame_err  out  1  sticky: stop bit sampled 0
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: a byte completed while the FIFO was full

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): all outputs 0 except rx_empty=1. FSM=IDLE, FIFO pointers=0, baud counter=0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser before any use. The baud counter counts 0..DVSR-1 and emits a 1-cycle tick at DVSR-1. The counter is free-running.
- FSM states: IDLE, START, DATA, PAR, STOP. Tick counter s (4 bit), bit counter n.
- IDLE: on synchronised rx=0 -> START with s=0.
- START: at s=7, if rx=0 -> DATA with s=0, n=0. If rx=1 (glitch) -> IDLE; no error raised, no byte produced.
- DATA: every 16 ticks, sample rx into the shift register LSB-first. After DBIT bits -> PAR if PARITY!=0, otherwise STOP.
- PAR: sample at 16 ticks and compare to the even/odd parity of the data.
- STOP: sample at the first 16 ticks; a 0 sets frame_err. Return to IDLE when s reaches SB_TICK-1.
- Frame completion (one cycle, "done"):
  - If a frame or parity error occurred, the byte is discarded and the flag is set.
  - Otherwise the byte is written to the FIFO, or dropped with overrun=1 if the FIFO is full and no pop occurs in the same cycle.
- Error flags are sticky until err_clr. If err_clr and a new error coincide, the flag ends up 1.
- FIFO write is registered: rx_empty drops 1 cycle after done.
- FIFO read and write in the same cycle: both happen, fill unchanged. This also applies when full: the write is accepted and no overrun is raised.
- A pop on empty is ignored. Pointers wrap modulo 2**FIFO_W. fill is in the range 0..2**FIFO_W.
- AUTO_POP=1: when rx_empty=0 and no pop occurred last cycle, issue an internal pop. On that edge, word<=r_data and word_valid=1. At most one pop every 2 cycles.
- AUTO_POP=0: word and word_valid track external rd pops the same way.
- Reset mid-frame: the frame is abandoned and the FIFO is cleared.
- After the line is held low (break), the FSM resynchronises only after rx returns high for at least one tick in IDLE.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state encoding;
  - divisor function dvsr(CLK_HZ, BAUD) and its width via $clog2.
- One sub-module: uart_sync_fifo (B, W), a registered sync FIFO with empty, full and fill outputs and simultaneous read+write support.
- The baud counter, synchroniser and FSM stay inline.

Test Plan:
- Defaults, send 0x41 at 9600 (bit = 6768 clk): word=0x41, word_valid pulses once, rx_empty returns to 1, no errors.
- PARITY=1, send 0x03 with parity bit 1 (wrong): parity_err=1, no word_valid, FIFO stays empty. Pulse err_clr: flag=0.
- Send 0x55 with stop bit forced 0: frame_err=1, byte dropped. Next clean 0xAA is received correctly.
- AUTO_POP=0, FIFO_W=2, send 5 bytes 0x01..0x05 with no rd: fill=4, rx_full=1, overrun=1. Pops return 0x01..0x04 in order.
- Glitch: rx low for 3 ticks (about 1269 clk), then high: FSM back to IDLE, no byte, no error.
- Assert reset_n=0 mid-DATA of 0x7E, release, send 0x12: outputs zeroed asynchronously, then only 0x12 is received.
